// File: rtl/alu_exec_unit_if.sv
// Request/response bundle of the execute-stage ALU.
// The unit drives in_ready and the result side.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic [3:0]      alu_ctrl;
    logic            zero;
    logic            lt;
    logic            ltu;
    logic            illegal;

    modport master (
        output in_valid, alu_op, funct3, funct7, op_a, op_b,
        input  in_ready, out_valid, result, alu_ctrl,
        input  zero, lt, ltu, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct3, funct7, op_a, op_b,
        output in_ready, out_valid, result, alu_ctrl,
        output zero, lt, ltu, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decode, single-cycle ops and
// iterative shift-add multiply / restoring divide.
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic clk,
    input  logic rst,
    alu_exec_unit_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] C_AND  = 4'h0, C_OR   = 4'h1;
    localparam logic [3:0] C_ADD  = 4'h2, C_XOR  = 4'h3;
    localparam logic [3:0] C_SLL  = 4'h4, C_SRL  = 4'h5;
    localparam logic [3:0] C_SUB  = 4'h6, C_SLT  = 4'h7;
    localparam logic [3:0] C_SRA  = 4'h8, C_SLTU = 4'h9;
    localparam logic [3:0] C_MUL  = 4'hA, C_DIV  = 4'hB;
    localparam logic [3:0] C_DIVU = 4'hC, C_REM  = 4'hD;
    localparam logic [3:0] C_REMU = 4'hE, C_ILL  = 4'hF;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      op_r;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] x, y, z;

    logic            out_valid_r, zero_r, lt_r, ltu_r, ill_r;
    logic [XLEN-1:0] res_r;
    logic [3:0]      ctrl_r;

    logic            hold_v, hold_lt, hold_ltu, hold_ill;
    logic [XLEN-1:0] hold_res;
    logic [3:0]      hold_ctrl;

    logic [XLEN-1:0] a, b, abs_a, abs_b;
    logic [SW-1:0]   sh;
    logic [3:0]      dec;
    logic            is_div, signed_div, div0, ovf, start_m;
    logic            done, accept;

    assign a  = bus.op_a;
    assign b  = bus.op_b;
    assign sh = b[SW-1:0];

    always_comb begin
        dec = C_ILL;
        case (bus.alu_op)
            2'b00: dec = C_ADD;
            2'b01: begin
                if (bus.funct3 != 3'b010 && bus.funct3 != 3'b011)
                    dec = C_SUB;
            end
            2'b10: begin
                if (bus.funct7 == 7'b0000000) begin
                    case (bus.funct3)
                        3'b000:  dec = C_ADD;
                        3'b001:  dec = C_SLL;
                        3'b010:  dec = C_SLT;
                        3'b011:  dec = C_SLTU;
                        3'b100:  dec = C_XOR;
                        3'b101:  dec = C_SRL;
                        3'b110:  dec = C_OR;
                        default: dec = C_AND;
                    endcase
                end else if (bus.funct7 == 7'b0100000) begin
                    if (bus.funct3 == 3'b000)
                        dec = C_SUB;
                    else if (bus.funct3 == 3'b101)
                        dec = C_SRA;
                end else if (ENABLE_M && bus.funct7 == 7'b0000001) begin
                    case (bus.funct3)
                        3'b000:  dec = C_MUL;
                        3'b100:  dec = C_DIV;
                        3'b101:  dec = C_DIVU;
                        3'b110:  dec = C_REM;
                        3'b111:  dec = C_REMU;
                        default: dec = C_ILL;
                    endcase
                end
            end
            default: dec = C_ILL;
        endcase
    end

    assign is_div = (dec == C_DIV) || (dec == C_DIVU) ||
                    (dec == C_REM) || (dec == C_REMU);
    assign signed_div = (dec == C_DIV) || (dec == C_REM);
    assign div0  = (b == '0);
    assign ovf   = signed_div && (a == MINV) && (b == '1);
    assign abs_a = (signed_div && a[XLEN-1]) ? -a : a;
    assign abs_b = (signed_div && b[XLEN-1]) ? -b : b;
    assign start_m = ENABLE_M &&
                     ((dec == C_MUL) || (is_div && !div0 && !ovf));

    logic [XLEN-1:0] s_res;
    logic            s_lt, s_ltu, s_ill;

    // Division shortcuts share the single-cycle path
    always_comb begin
        s_res = '0;
        s_lt  = 1'b0;
        s_ltu = 1'b0;
        case (dec)
            C_AND:  s_res = a & b;
            C_OR:   s_res = a | b;
            C_ADD:  s_res = a + b;
            C_XOR:  s_res = a ^ b;
            C_SLL:  s_res = a << sh;
            C_SRL:  s_res = a >> sh;
            C_SUB:  s_res = a - b;
            C_SLT:  s_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            C_SRA:  s_res = $unsigned($signed(a) >>> sh);
            C_SLTU: s_res = {{(XLEN-1){1'b0}}, a < b};
            C_DIV, C_DIVU: s_res = div0 ? '1 : a;
            C_REM, C_REMU: s_res = div0 ? a : '0;
            default: s_res = '0;
        endcase
        if (bus.alu_op == 2'b01 && dec == C_SUB) begin
            s_lt  = $signed(a) < $signed(b);
            s_ltu = a < b;
        end
    end
    assign s_ill = (dec == C_ILL);

    logic [XLEN-1:0] mul_sum, div_quo, div_rem, m_res;
    logic [XLEN:0]   div_sh, div_tr;
    logic            div_ge;

    assign mul_sum = x + (z[0] ? y : '0);
    assign div_sh  = {x, y[XLEN-1]};
    assign div_tr  = div_sh - {1'b0, z};
    assign div_ge  = !div_tr[XLEN];
    assign div_rem = div_ge ? div_tr[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_quo = {y[XLEN-2:0], div_ge};

    always_comb begin
        case (op_r)
            C_DIV:   m_res = neg_q ? -div_quo : div_quo;
            C_DIVU:  m_res = div_quo;
            C_REM:   m_res = neg_r ? -div_rem : div_rem;
            C_REMU:  m_res = div_rem;
            default: m_res = mul_sum;
        endcase
    end

    assign done   = (state != IDLE) && (cnt == CW'(1));
    // A non-M op accepted on the completion edge waits one cycle in hold
    assign bus.in_ready = !rst && !hold_v && ((state == IDLE) || done);
    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_r        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            out_valid_r <= 1'b0;
            res_r       <= '0;
            ctrl_r      <= '0;
            zero_r      <= 1'b0;
            lt_r        <= 1'b0;
            ltu_r       <= 1'b0;
            ill_r       <= 1'b0;
            hold_v      <= 1'b0;
            hold_res    <= '0;
            hold_ctrl   <= '0;
            hold_lt     <= 1'b0;
            hold_ltu    <= 1'b0;
            hold_ill    <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (done) begin
                out_valid_r <= 1'b1;
                res_r       <= m_res;
                ctrl_r      <= op_r;
                zero_r      <= (m_res == '0);
                lt_r        <= 1'b0;
                ltu_r       <= 1'b0;
                ill_r       <= 1'b0;
                state       <= IDLE;
            end else if (hold_v) begin
                out_valid_r <= 1'b1;
                res_r       <= hold_res;
                ctrl_r      <= hold_ctrl;
                zero_r      <= (hold_res == '0);
                lt_r        <= hold_lt;
                ltu_r       <= hold_ltu;
                ill_r       <= hold_ill;
                hold_v      <= 1'b0;
            end
            case (state)
                MUL: begin
                    x   <= mul_sum;
                    y   <= y << 1;
                    z   <= z >> 1;
                    cnt <= cnt - 1'b1;
                end
                DIV: begin
                    x   <= div_rem;
                    y   <= div_quo;
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
            if (accept) begin
                if (start_m) begin
                    state <= (dec == C_MUL) ? MUL : DIV;
                    cnt   <= CW'(XLEN);
                    op_r  <= dec;
                    x     <= '0;
                    y     <= (dec == C_MUL) ? a : abs_a;
                    z     <= (dec == C_MUL) ? b : abs_b;
                    neg_q <= signed_div && (a[XLEN-1] ^ b[XLEN-1]);
                    neg_r <= signed_div && a[XLEN-1];
                end else if (done) begin
                    hold_v    <= 1'b1;
                    hold_res  <= s_res;
                    hold_ctrl <= dec;
                    hold_lt   <= s_lt;
                    hold_ltu  <= s_ltu;
                    hold_ill  <= s_ill;
                end else begin
                    out_valid_r <= 1'b1;
                    res_r       <= s_res;
                    ctrl_r      <= dec;
                    zero_r      <= (s_res == '0);
                    lt_r        <= s_lt;
                    ltu_r       <= s_ltu;
                    ill_r       <= s_ill;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.result    = res_r;
    assign bus.alu_ctrl  = ctrl_r;
    assign bus.zero      = zero_r;
    assign bus.lt        = lt_r;
    assign bus.ltu       = ltu_r;
    assign bus.illegal   = ill_r;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decode. Decodes ALUOp/funct3/funct7 to an extended 4-bit ALU code and executes the operation, with a registered result.
- Adds RV32M-style MUL/DIV/DIVU/REM/REMU, run as iterative multi-cycle operations behind a valid/ready handshake.
- Sits in the execute stage between register read and writeback/branch resolution.

Parameters:
- XLEN, 32: operand and result width (≥8, power of 2).
- ENABLE_M, 1: 1 decodes funct7=0000001 (ALUOp=10) as M-extension; 0 makes those encodings illegal.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- alu_op  in  2  00 load/store, 01 branch, 10 R/I-type
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7 (forced 0 by decoder for I-type except SRAI)
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B (register or immediate)
- out_valid  out  1  one-cycle pulse; result and flags valid
- result  out  XLEN  operation result
- alu_ctrl  out  4  decoded code of the completed op
- zero  out  1  result == 0
- lt  out  1  signed op_a < op_b (branch ops)
- ltu  out  1  unsigned op_a < op_b (branch ops)
- illegal  out  1  completed op was an undecodable encoding

Behaviour:
- Reset: in_ready=0 in the reset cycle and 1 afterwards. out_valid, result, alu_ctrl, zero, lt, ltu and illegal are all 0. FSM=IDLE, counter=0.
- Accept: in_valid & in_ready at a rising edge. Inputs are sampled only then.
- Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, SLTU 1001, MUL 1010, DIV 1011, DIVU 1100, REM 1101, REMU 1110, illegal 1111.
- Decode, alu_op=00: ADD.
- Decode, alu_op=01: SUB. lt and ltu are computed. funct3 outside {000,001,100,101,110,111} is illegal.
- Decode, alu_op=10, funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- Decode, alu_op=10, funct7=0100000: funct3 000 SUB, 101 SRA.
- Decode, alu_op=10, funct7=0000001 and ENABLE_M=1: funct3 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Decode, anything else: illegal. alu_op=11 is illegal.
- Illegal ops: result=0, illegal=1, latency 1.
- Shift amount: op_b[log2(XLEN)-1:0].
- Arithmetic wraps modulo 2^XLEN.
- Single-cycle ops: result registered at the accept edge; out_valid=1 for exactly the next cycle. in_ready stays 1, so back-to-back accepts give back-to-back out_valid.
- FSM states: IDLE, MUL, DIV.
- IDLE → MUL/DIV on accepting an M op with no shortcut. At the accept edge, load operands (absolute values for signed DIV/REM), record the result signs and set counter=XLEN. in_ready=0 while in MUL/DIV.
- MUL: shift-add, one bit per cycle. Lower XLEN bits only, so signedness is irrelevant.
- DIV: restoring division, one quotient bit per cycle.
- On the edge where counter==1: the final iteration completes, result is written with sign correction, out_valid pulses next cycle and FSM returns to IDLE. in_ready=1 in that same cycle.
- Latency for M ops: XLEN cycles from the accept edge to the out_valid cycle.
- Divide-by-zero shortcut, latency 1: DIV/DIVU result = all ones; REM/REMU result = op_a.
- Signed overflow shortcut (op_a = -2^(XLEN-1), op_b = -1), latency 1: DIV result = op_a; REM result = 0.
- Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Flags: zero reflects result for every op. lt and ltu are meaningful only for alu_op=01 and are 0 otherwise.
- out_valid has no backpressure. The consumer must take the result in the out_valid cycle.
- in_valid while BUSY is ignored (not accepted). The requester holds it.
- rst during MUL/DIV: abort, return to IDLE, no out_valid for the aborted op, all outputs cleared.
- ENABLE_M=0: no MUL/DIV states are synthesised. in_ready is constantly 1 after reset.

Test Plan:
- Reset then alu_op=00, op_a=0x10, op_b=0x4 → next cycle out_valid=1, result=0x14, alu_ctrl=0010, zero=0.
- Branch alu_op=01, funct3=100, op_a=0xFFFFFFFF, op_b=1 → SUB result 0xFFFFFFFE; lt=1, ltu=0.
- R-type SRA funct7=0100000, op_a=0x80000000, op_b=4 → 0xF8000000. Back-to-back with XOR 0xFF^0x0F → 0xF0 on the following cycle.
- MUL funct7=0000001, op_a=0xFFFFFFFF (-1), op_b=7 → in_ready=0 for 31 cycles, out_valid 32 cycles after accept, result 0xFFFFFFF9. An in_valid pulse while busy is not accepted.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU x/0 → 0xFFFFFFFF at latency 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000, latency 1.
- Start DIVU, assert rst at cycle 10 → no out_valid, all outputs 0. A new ADD is accepted normally after reset deasserts. funct7=0000011 → illegal=1, alu_ctrl=1111, result=0.
